// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the data-RAM arbiter and its three neighbours: the CPU
// load/store port, the byte-serial host port and the single-port data RAM.
interface dmem_port_arbiter_if #(
  parameter int AW = 5
) ();
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [31:0]   cpu_rdata;

  logic          host_cmd_valid;
  logic          host_cmd_write;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_byte_in;
  logic          host_byte_valid;
  logic [7:0]    host_byte_out;
  logic          host_byte_out_valid;
  logic          host_busy;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  host_cmd_valid, host_cmd_write, host_addr, host_byte_in, host_byte_valid,
    output host_byte_out, host_byte_out_valid, host_busy,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output host_cmd_valid, host_cmd_write, host_addr, host_byte_in, host_byte_valid,
    input  host_byte_out, host_byte_out_valid, host_busy,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data RAM between the CPU load/store port and a
// byte-serial host load/dump port; CPU has priority, bounded by a starvation guard.
module dmem_port_arbiter #(
  parameter int AW           = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  dmem_port_arbiter_if.slave bus
);
  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    H_IDLE    = 3'd0,
    H_COLLECT = 3'd1,
    H_REQ     = 3'd2,
    H_WAIT    = 3'd3,
    H_SEND    = 3'd4
  } host_state_e;

  host_state_e   state_q, state_d;
  logic          cmd_write_q, cmd_write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          busy_q, busy_d;
  logic [7:0]    byte_out_q, byte_out_d;
  logic          byte_out_valid_q, byte_out_valid_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic [AW-1:0] ram_addr_q;

  logic          host_req_s;
  logic          host_win_s;
  logic          cpu_gnt_s;
  logic          ram_we_s;
  logic [AW-1:0] ram_addr_s;
  logic [31:0]   ram_wdata_s;

  // Arbitration, starvation counter and RAM port mux; reset suppresses every grant
  always_comb begin
    host_req_s   = (state_q == H_REQ) && !rst;
    host_win_s   = host_req_s && (!bus.cpu_req || (starve_q == STARVE_MAX));
    cpu_gnt_s    = bus.cpu_req && !host_win_s && !rst;
    starve_d     = '0;
    ram_we_s     = 1'b0;
    ram_addr_s   = ram_addr_q;
    ram_wdata_s  = 32'h0000_0000;
    if (host_req_s && !host_win_s) begin
      if (starve_q == STARVE_MAX) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + SW'(1);
      end
    end else begin
      starve_d = '0;
    end
    if (host_win_s) begin
      ram_we_s    = cmd_write_q;
      ram_addr_s  = addr_q;
      ram_wdata_s = data_q;
    end else if (cpu_gnt_s) begin
      ram_we_s    = bus.cpu_we;
      ram_addr_s  = bus.cpu_addr;
      ram_wdata_s = bus.cpu_wdata;
    end else begin
      ram_we_s    = 1'b0;
      ram_addr_s  = ram_addr_q;
      ram_wdata_s = 32'h0000_0000;
    end
    cpu_rvalid_d = cpu_gnt_s && !bus.cpu_we;
  end

  // Host command sequencer; data_q doubles as byte collector and output shifter
  always_comb begin
    state_d          = state_q;
    cmd_write_d      = cmd_write_q;
    addr_d           = addr_q;
    data_d           = data_q;
    cnt_d            = cnt_q;
    busy_d           = busy_q;
    byte_out_d       = 8'h00;
    byte_out_valid_d = 1'b0;
    case (state_q)
      H_IDLE: begin
        if (bus.host_cmd_valid) begin
          addr_d      = bus.host_addr;
          cmd_write_d = bus.host_cmd_write;
          busy_d      = 1'b1;
          cnt_d       = 2'd0;
          state_d     = bus.host_cmd_write ? H_COLLECT : H_REQ;
        end else begin
          busy_d      = 1'b0;
        end
      end
      H_COLLECT: begin
        // Shifting in from the top leaves the first byte in bits 7:0 after four bytes
        if (bus.host_byte_valid) begin
          data_d = {bus.host_byte_in, data_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = H_REQ;
          end else begin
            state_d = H_COLLECT;
          end
        end else begin
          state_d = H_COLLECT;
        end
      end
      H_REQ: begin
        if (host_win_s) begin
          if (cmd_write_q) begin
            state_d = H_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = H_WAIT;
          end
        end else begin
          state_d = H_REQ;
        end
      end
      H_WAIT: begin
        byte_out_d       = bus.ram_rdata[7:0];
        byte_out_valid_d = 1'b1;
        data_d           = {8'h00, bus.ram_rdata[31:8]};
        cnt_d            = 2'd0;
        state_d          = H_SEND;
      end
      H_SEND: begin
        if (cnt_q == 2'd3) begin
          state_d = H_IDLE;
          busy_d  = 1'b0;
        end else begin
          byte_out_d       = data_q[7:0];
          byte_out_valid_d = 1'b1;
          data_d           = data_q >> 8;
          cnt_d            = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = H_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= H_IDLE;
      cmd_write_q      <= 1'b0;
      addr_q           <= '0;
      data_q           <= 32'h0000_0000;
      cnt_q            <= 2'd0;
      starve_q         <= '0;
      busy_q           <= 1'b0;
      byte_out_q       <= 8'h00;
      byte_out_valid_q <= 1'b0;
      cpu_rvalid_q     <= 1'b0;
      ram_addr_q       <= '0;
    end else begin
      state_q          <= state_d;
      cmd_write_q      <= cmd_write_d;
      addr_q           <= addr_d;
      data_q           <= data_d;
      cnt_q            <= cnt_d;
      starve_q         <= starve_d;
      busy_q           <= busy_d;
      byte_out_q       <= byte_out_d;
      byte_out_valid_q <= byte_out_valid_d;
      cpu_rvalid_q     <= cpu_rvalid_d;
      ram_addr_q       <= ram_addr_s;
    end
  end

  assign bus.cpu_gnt             = cpu_gnt_s;
  assign bus.cpu_rvalid          = cpu_rvalid_q;
  assign bus.cpu_rdata           = cpu_rvalid_q ? bus.ram_rdata : 32'h0000_0000;
  assign bus.host_byte_out       = byte_out_q;
  assign bus.host_byte_out_valid = byte_out_valid_q;
  assign bus.host_busy           = busy_q;
  assign bus.ram_we              = ram_we_s;
  assign bus.ram_addr            = ram_addr_s;
  assign bus.ram_wdata           = ram_wdata_s;
endmodule
